// File: rtl/a5_alu_sequencer.sv
// Execute/write-back sequencer for the A5 register set. It fetches operands, then
// computes an ALU or iterative 16x16 multiply result and issues one write-back strobe.
module a5_alu_sequencer #(
    parameter bit MulEn = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        op_valid_i,
    output logic        op_ready_o,
    input  logic [2:0]  opcode_i,
    input  logic [2:0]  src_a_i,
    input  logic [2:0]  src_b_i,
    input  logic [2:0]  dst_i,
    output logic [2:0]  reg_1_o,
    output logic [2:0]  reg_2_o,
    output logic [2:0]  reg_wr_o,
    output logic        write_enable_o,
    output logic [15:0] write_data_o,
    output logic [16:0] temp_alu_result_o,
    input  logic [15:0] read_a_i,
    input  logic [15:0] read_b_i,
    output logic        done_o,
    output logic        err_o
);

    typedef enum logic [2:0] {StIdle, StRead, StExec, StMul, StWb} state_e;

    localparam logic [2:0] OpAdd = 3'b000;
    localparam logic [2:0] OpSub = 3'b001;
    localparam logic [2:0] OpAnd = 3'b010;
    localparam logic [2:0] OpOr  = 3'b011;
    localparam logic [2:0] OpXor = 3'b100;
    localparam logic [2:0] OpShl = 3'b101;
    localparam logic [2:0] OpMul = 3'b110;
    localparam logic [2:0] OpNop = 3'b111;

    state_e      state_q;
    logic [2:0]  opcode_q;
    logic [2:0]  dst_q;
    logic        op_ready_q;
    logic [2:0]  reg_1_q;
    logic [2:0]  reg_2_q;
    logic [2:0]  reg_wr_q;
    logic        write_enable_q;
    logic [15:0] write_data_q;
    logic [16:0] temp_q;
    logic        done_q;
    logic        err_q;
    logic [31:0] mcand_q;
    logic [15:0] mplier_q;
    logic [31:0] acc_q;
    logic [3:0]  cnt_q;

    logic        illegal;
    logic [16:0] alu_res;
    logic [31:0] acc_next;
    logic [16:0] mul_res;

    always_comb begin
        illegal = (src_a_i > 3'd4) || (src_b_i > 3'd4) || (dst_i > 3'd4) ||
                  (opcode_i == OpNop) || ((opcode_i == OpMul) && !MulEn);
    end

    always_comb begin
        alu_res = '0;
        case (opcode_q)
            OpAdd:   alu_res = {1'b0, read_a_i} + {1'b0, read_b_i};
            OpSub:   alu_res = {1'b0, read_a_i} - {1'b0, read_b_i};
            OpAnd:   alu_res = {1'b0, read_a_i & read_b_i};
            OpOr:    alu_res = {1'b0, read_a_i | read_b_i};
            OpXor:   alu_res = {1'b0, read_a_i ^ read_b_i};
            OpShl:   alu_res = {read_a_i, 1'b0};
            default: alu_res = '0;
        endcase
    end

    // Shift-add step; the last step's sum is folded straight into the result.
    always_comb begin
        acc_next = acc_q + (mplier_q[0] ? mcand_q : 32'd0);
        mul_res  = {|acc_next[31:16], acc_next[15:0]};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= StIdle;
            opcode_q       <= '0;
            dst_q          <= '0;
            op_ready_q     <= 1'b1;
            reg_1_q        <= '0;
            reg_2_q        <= '0;
            reg_wr_q       <= '0;
            write_enable_q <= 1'b0;
            write_data_q   <= '0;
            temp_q         <= '0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
            mcand_q        <= '0;
            mplier_q       <= '0;
            acc_q          <= '0;
            cnt_q          <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (op_valid_i && op_ready_q) begin
                        op_ready_q <= 1'b0;
                        opcode_q   <= opcode_i;
                        dst_q      <= dst_i;
                        if (illegal) begin
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                            state_q <= StWb;
                        end else begin
                            reg_1_q <= src_a_i;
                            reg_2_q <= src_b_i;
                            state_q <= StRead;
                        end
                    end
                end
                StRead: begin
                    state_q <= StExec;
                end
                StExec: begin
                    if (opcode_q == OpMul) begin
                        mcand_q  <= {16'd0, read_a_i};
                        mplier_q <= read_b_i;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        state_q  <= StMul;
                    end else begin
                        reg_wr_q       <= dst_q;
                        write_data_q   <= alu_res[15:0];
                        temp_q         <= alu_res;
                        write_enable_q <= 1'b1;
                        done_q         <= 1'b1;
                        err_q          <= 1'b0;
                        state_q        <= StWb;
                    end
                end
                StMul: begin
                    acc_q    <= acc_next;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        reg_wr_q       <= dst_q;
                        write_data_q   <= mul_res[15:0];
                        temp_q         <= mul_res;
                        write_enable_q <= 1'b1;
                        done_q         <= 1'b1;
                        err_q          <= 1'b0;
                        state_q        <= StWb;
                    end
                end
                StWb: begin
                    write_enable_q <= 1'b0;
                    done_q         <= 1'b0;
                    err_q          <= 1'b0;
                    op_ready_q     <= 1'b1;
                    state_q        <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign op_ready_o        = op_ready_q;
    assign reg_1_o           = reg_1_q;
    assign reg_2_o           = reg_2_q;
    assign reg_wr_o          = reg_wr_q;
    assign write_enable_o    = write_enable_q;
    assign write_data_o      = write_data_q;
    assign temp_alu_result_o = temp_q;
    assign done_o            = done_q;
    assign err_o             = err_q;

endmodule

// File: tb/tb_a5_alu_sequencer.sv
// Bench for a5_alu_sequencer: a behavioural register set plus an arithmetic reference
// model that checks results, latency and strobes for directed and random operations.
module tb_a5_alu_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        op_valid;
    logic        op_valid_nm;
    logic [2:0]  opcode;
    logic [2:0]  src_a;
    logic [2:0]  src_b;
    logic [2:0]  dst;
    logic        op_ready;
    logic [2:0]  reg_1;
    logic [2:0]  reg_2;
    logic [2:0]  reg_wr;
    logic        write_enable;
    logic [15:0] write_data;
    logic [16:0] temp;
    logic        done;
    logic        err;
    logic [15:0] rd_a;
    logic [15:0] rd_b;

    logic        nm_ready;
    logic [2:0]  nm_reg_1;
    logic [2:0]  nm_reg_2;
    logic [2:0]  nm_reg_wr;
    logic        nm_we;
    logic [15:0] nm_wd;
    logic [16:0] nm_temp;
    logic        nm_done;
    logic        nm_err;

    logic [15:0] rf [8];
    logic [15:0] model_rf [8];
    logic        load_en;
    logic [2:0]  load_idx;
    logic [15:0] load_val;

    int checks = 0;
    int errors = 0;

    a5_alu_sequencer #(.MulEn(1'b1)) dut (
        .clk_i(clk), .rst_ni(rst_n), .op_valid_i(op_valid), .op_ready_o(op_ready),
        .opcode_i(opcode), .src_a_i(src_a), .src_b_i(src_b), .dst_i(dst),
        .reg_1_o(reg_1), .reg_2_o(reg_2), .reg_wr_o(reg_wr), .write_enable_o(write_enable),
        .write_data_o(write_data), .temp_alu_result_o(temp), .read_a_i(rd_a),
        .read_b_i(rd_b), .done_o(done), .err_o(err)
    );

    a5_alu_sequencer #(.MulEn(1'b0)) dut_nm (
        .clk_i(clk), .rst_ni(rst_n), .op_valid_i(op_valid_nm), .op_ready_o(nm_ready),
        .opcode_i(opcode), .src_a_i(src_a), .src_b_i(src_b), .dst_i(dst),
        .reg_1_o(nm_reg_1), .reg_2_o(nm_reg_2), .reg_wr_o(nm_reg_wr),
        .write_enable_o(nm_we), .write_data_o(nm_wd), .temp_alu_result_o(nm_temp),
        .read_a_i(rd_a), .read_b_i(rd_b), .done_o(nm_done), .err_o(nm_err)
    );

    // Register set: registered reads, write on the strobe, bench preload port.
    always @(posedge clk) begin
        rd_a <= rf[reg_1];
        rd_b <= rf[reg_2];
        if (load_en) rf[load_idx] <= load_val;
        else if (write_enable) rf[reg_wr] <= write_data;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] ref_alu(input logic [2:0] opc, input logic [15:0] a,
                                            input logic [15:0] b);
        int unsigned     ua;
        int unsigned     ub;
        longint unsigned p;
        ua = a;
        ub = b;
        case (opc)
            3'd0: return 17'(ua + ub);
            3'd1: return 17'(ua - ub);
            3'd2: return {1'b0, a & b};
            3'd3: return {1'b0, a | b};
            3'd4: return {1'b0, a ^ b};
            3'd5: return 17'(ua * 2);
            3'd6: begin
                p = 64'(ua) * 64'(ub);
                return {(p > 64'hFFFF), p[15:0]};
            end
            default: return '0;
        endcase
    endfunction

    task automatic set_reg(input logic [2:0] idx, input logic [15:0] val);
        load_en     = 1'b1;
        load_idx    = idx;
        load_val    = val;
        model_rf[idx] = val;
        @(posedge clk);
        #1;
        load_en = 1'b0;
    endtask

    task automatic run_op(input logic [2:0] opc, input logic [2:0] sa, input logic [2:0] sb,
                          input logic [2:0] d, output logic [16:0] got_temp);
        logic        legal;
        logic [16:0] exp;
        logic [2:0]  r1;
        logic [2:0]  r2;
        logic [15:0] got_wd;
        logic [2:0]  got_wr;
        logic        got_err;
        int          n;
        int          k;
        int          lat;
        int          exp_lat;
        int          done_k;
        int          done_n;
        int          we_n;
        int          mism;
        legal   = (sa <= 3'd4) && (sb <= 3'd4) && (d <= 3'd4) && (opc != 3'd7);
        exp     = legal ? ref_alu(opc, model_rf[sa], model_rf[sb]) : 17'd0;
        exp_lat = !legal ? 2 : (opc == 3'd6) ? 20 : 4;
        n = 0;
        while (!op_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("ready_wait", 32'(op_ready), 32'd1);
        opcode   = opc;
        src_a    = sa;
        src_b    = sb;
        dst      = d;
        op_valid = 1'b1;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        r1 = reg_1;
        r2 = reg_2;
        k = 0; lat = -1; done_k = -1; done_n = 0; we_n = 0; mism = 0;
        got_temp = '0; got_wd = '0; got_wr = '0; got_err = 1'b0;
        while (k < 40) begin
            if (write_enable !== (done && legal)) mism++;
            if (done) begin
                done_n++;
                done_k   = k;
                got_temp = temp;
                got_wd   = write_data;
                got_wr   = reg_wr;
                got_err  = err;
            end
            if (write_enable) we_n++;
            if (op_ready) begin
                lat = k + 1;
                break;
            end
            @(posedge clk);
            #1;
            k++;
        end
        check_eq("latency", lat, exp_lat);
        check_eq("done_cycle", done_k, exp_lat - 2);
        check_eq("done_count", done_n, 1);
        check_eq("we_vs_done", mism, 0);
        check_eq("we_count", we_n, legal ? 1 : 0);
        check_eq("err", 32'(got_err), legal ? 32'd0 : 32'd1);
        if (legal) begin
            check_eq("reg_1", 32'(r1), 32'(sa));
            check_eq("reg_2", 32'(r2), 32'(sb));
            check_eq("temp", 32'(got_temp), 32'(exp));
            check_eq("write_data", 32'(got_wd), 32'(exp[15:0]));
            check_eq("reg_wr", 32'(got_wr), 32'(d));
            model_rf[d] = exp[15:0];
            check_eq("rf_update", 32'(rf[d]), 32'(model_rf[d]));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [16:0] t;
        logic [2:0]  ropc;
        logic [2:0]  rsa;
        logic [2:0]  rsb;
        logic [2:0]  rd;
        int          cnt_we;
        int          cnt_done;
        rst_n = 1'b0; op_valid = 1'b0; op_valid_nm = 1'b0; load_en = 1'b0;
        load_idx = '0; load_val = '0; opcode = '0; src_a = '0; src_b = '0; dst = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ready", 32'(op_ready), 32'd1);
        check_eq("rst_ctl", 32'({reg_1, reg_2, reg_wr, write_enable, done, err}), 32'd0);
        check_eq("rst_temp", 32'(temp), 32'd0);
        check_eq("rst_wd", 32'(write_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) set_reg(3'(i), 16'($urandom));

        set_reg(3'd0, 16'h0001); set_reg(3'd1, 16'h0007);
        run_op(3'd0, 3'd0, 3'd1, 3'd2, t);
        check_eq("add_basic", 32'(t), 32'h00008);

        set_reg(3'd0, 16'hFFFF); set_reg(3'd1, 16'h0001);
        run_op(3'd0, 3'd0, 3'd1, 3'd2, t);
        check_eq("add_carry", 32'(t), 32'h10000);
        check_eq("add_carry_wd", 32'(rf[2]), 32'h0000);
        set_reg(3'd0, 16'h0001); set_reg(3'd1, 16'h0007);
        run_op(3'd1, 3'd0, 3'd1, 3'd2, t);
        check_eq("sub_borrow", 32'(t), 32'h1FFFA);
        set_reg(3'd0, 16'h0005);
        run_op(3'd1, 3'd0, 3'd0, 3'd3, t);
        check_eq("sub_zero", 32'(t), 32'h00000);

        set_reg(3'd0, 16'h0003); set_reg(3'd1, 16'h0007);
        run_op(3'd6, 3'd0, 3'd1, 3'd2, t);
        check_eq("mul_small", 32'(t), 32'h00015);
        set_reg(3'd0, 16'h0100);
        run_op(3'd6, 3'd0, 3'd0, 3'd2, t);
        check_eq("mul_ovf", 32'(t), 32'h10000);

        opcode = 3'd6; src_a = 3'd0; src_b = 3'd1; dst = 3'd2; op_valid_nm = 1'b1;
        @(posedge clk);
        #1;
        op_valid_nm = 1'b0;
        check_eq("nomul_done", 32'(nm_done), 32'd1);
        check_eq("nomul_err", 32'(nm_err), 32'd1);
        cnt_we = 0;
        for (int i = 0; i < 4; i++) begin
            if (nm_we) cnt_we++;
            @(posedge clk);
            #1;
        end
        check_eq("nomul_no_we", cnt_we, 0);
        check_eq("nomul_ready", 32'(nm_ready), 32'd1);

        run_op(3'd0, 3'd0, 3'd1, 3'd5, t);
        run_op(3'd7, 3'd0, 3'd1, 3'd2, t);
        run_op(3'd2, 3'd6, 3'd1, 3'd2, t);

        set_reg(3'd0, 16'h0003); set_reg(3'd1, 16'h0005);
        run_op(3'd0, 3'd0, 3'd1, 3'd3, t);
        run_op(3'd0, 3'd3, 3'd3, 3'd4, t);
        check_eq("dep_add", 32'(t), 32'h00010);

        for (int i = 0; i < 40; i++) begin
            ropc = 3'($urandom_range(0, 7));
            rsa  = 3'($urandom_range(0, 4));
            rsb  = 3'($urandom_range(0, 4));
            rd   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7))
                                              : 3'($urandom_range(0, 4));
            if ($urandom_range(0, 3) == 0) set_reg(rsa, 16'($urandom));
            run_op(ropc, rsa, rsb, rd, t);
        end

        set_reg(3'd0, 16'h1234); set_reg(3'd1, 16'h0042);
        opcode = 3'd6; src_a = 3'd0; src_b = 3'd1; dst = 3'd2; op_valid = 1'b1;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_ctl", 32'({reg_1, reg_2, reg_wr, write_enable, done, err}), 32'd0);
        check_eq("midrst_temp", 32'(temp), 32'd0);
        check_eq("midrst_wd", 32'(write_data), 32'd0);
        check_eq("midrst_ready", 32'(op_ready), 32'd1);
        #3;
        rst_n = 1'b1;
        cnt_we = 0;
        cnt_done = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            if (write_enable) cnt_we++;
            if (done) cnt_done++;
        end
        check_eq("midrst_no_we", cnt_we, 0);
        check_eq("midrst_no_done", cnt_done, 0);
        check_eq("midrst_ready_after", 32'(op_ready), 32'd1);
        run_op(3'd4, 3'd0, 3'd1, 3'd3, t);
        check_eq("after_rst_xor", 32'(t), 32'h01276);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
